// File: rtl/wdt_pkg.sv
// Shared offsets, unlock keys, lock states and STATUS bit positions for the watchdog register interface.
package wdt_pkg;

    localparam logic [2:0] OFF_CNTL   = 3'd0;
    localparam logic [2:0] OFF_CNTH   = 3'd1;
    localparam logic [2:0] OFF_RELL   = 3'd2;
    localparam logic [2:0] OFF_RELH   = 3'd3;
    localparam logic [2:0] OFF_CONFIG = 3'd4;
    localparam logic [2:0] OFF_KEY    = 3'd5;
    localparam logic [2:0] OFF_STATUS = 3'd6;

    localparam logic [7:0] KEY1_VAL = 8'h55;
    localparam logic [7:0] KEY2_VAL = 8'hAA;

    localparam int STS_UNLOCKED = 0;
    localparam int STS_KEY1     = 1;
    localparam int STS_STICKY   = 2;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        KEY1     = 2'd1,
        UNLOCKED = 2'd2
    } wdt_lock_e;

    function automatic logic is_protected(input logic [2:0] off);
        return (off == OFF_RELL) || (off == OFF_RELH) || (off == OFF_CONFIG);
    endfunction

endpackage

// File: rtl/wdt_unlock_fsm.sv
// Two-byte key unlock FSM with timed window, violation pulse and sticky flag.
// State, window and violation are registered: they take effect the cycle after the write; no backpressure.
module wdt_unlock_fsm
    import wdt_pkg::*;
#(
    parameter int UNLOCK_WINDOW = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr_hit,
    input  logic [2:0] i_off,
    input  logic [7:0] i_wdata,
    output logic       o_protected_ok,
    output wdt_lock_e  o_state,
    output logic       o_sticky,
    output logic       o_violation
);

    localparam logic [7:0] WIN_INIT = 8'(UNLOCK_WINDOW);

    wdt_lock_e  r_state;
    logic [7:0] r_window;
    logic       r_sticky;
    logic       r_violation;

    logic w_key_wr;
    logic w_prot_wr;
    logic w_cfg_wr;
    logic w_clr;
    logic w_viol;

    assign w_key_wr  = i_wr_hit && (i_off == OFF_KEY);
    assign w_prot_wr = i_wr_hit && is_protected(i_off);
    assign w_cfg_wr  = i_wr_hit && (i_off == OFF_CONFIG);
    assign w_clr     = i_wr_hit && (i_off == OFF_STATUS) && i_wdata[STS_STICKY];

    // In KEY1 anything except the second key byte aborts the sequence.
    always_comb begin
        w_viol = 1'b0;
        case (r_state)
            LOCKED:   w_viol = w_prot_wr;
            KEY1:     w_viol = i_wr_hit && !(w_key_wr && (i_wdata == KEY2_VAL));
            default:  w_viol = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= LOCKED;
            r_window    <= 8'd0;
            r_sticky    <= 1'b0;
            r_violation <= 1'b0;
        end else begin
            r_violation <= w_viol;
            if (w_viol)
                r_sticky <= 1'b1;
            else if (w_clr)
                r_sticky <= 1'b0;

            case (r_state)
                LOCKED: begin
                    if (w_key_wr && (i_wdata == KEY1_VAL))
                        r_state <= KEY1;
                end
                KEY1: begin
                    if (w_key_wr && (i_wdata == KEY2_VAL)) begin
                        r_state  <= UNLOCKED;
                        r_window <= WIN_INIT;
                    end else if (i_wr_hit) begin
                        r_state <= LOCKED;
                    end
                end
                UNLOCKED: begin
                    // Window value 1 is the last accepted cycle.
                    if (w_key_wr || w_cfg_wr || (r_window == 8'd1)) begin
                        r_state  <= LOCKED;
                        r_window <= 8'd0;
                    end else begin
                        r_window <= r_window - 8'd1;
                    end
                end
                default: begin
                    r_state  <= LOCKED;
                    r_window <= 8'd0;
                end
            endcase
        end
    end

    assign o_protected_ok = (r_state == UNLOCKED);
    assign o_state        = r_state;
    assign o_sticky       = r_sticky;
    assign o_violation    = r_violation;

endmodule

// File: rtl/wdt_regif.sv
// Byte-wide CPU I/O window onto the watchdog counter, reload and config registers.
// Write strobes and read data are registered (1 cycle); single-cycle accesses, no backpressure.
module wdt_regif
    import wdt_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR     = 8'h40,
    parameter int         UNLOCK_WINDOW = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        wr,
    input  logic        rd,
    output logic [7:0]  rdata,
    input  logic [15:0] wd_counter_rd,
    input  logic [15:0] wd_reload_rd,
    input  logic [7:0]  wd_config_rd,
    output logic [15:0] wd_counter_wr,
    output logic [15:0] wd_reload_wr,
    output logic [7:0]  wd_config_wr,
    output logic [1:0]  wd_counter_we,
    output logic [1:0]  wd_reload_we,
    output logic        wd_config_we,
    output logic        violation
);

    logic       w_hit;
    logic [2:0] w_off;
    logic       w_wr;
    logic       w_rd;
    logic       w_prot_ok;
    wdt_lock_e  w_state;
    logic       w_sticky;
    logic [7:0] w_status;
    logic [7:0] w_rmux;
    logic       w_rell_ok;
    logic       w_relh_ok;
    logic       w_cfg_ok;

    logic [7:0]  r_rdata;
    logic [7:0]  r_shadow;
    logic [15:0] r_counter_wr;
    logic [15:0] r_reload_wr;
    logic [7:0]  r_config_wr;
    logic [1:0]  r_counter_we;
    logic [1:0]  r_reload_we;
    logic        r_config_we;

    assign w_hit = (addr[7:3] == BASE_ADDR[7:3]);
    assign w_off = addr[2:0];
    assign w_wr  = w_hit && wr;
    assign w_rd  = w_hit && rd && !wr;

    wdt_unlock_fsm #(
        .UNLOCK_WINDOW (UNLOCK_WINDOW)
    ) u_fsm (
        .clk            (clk),
        .reset          (reset),
        .i_wr_hit       (w_wr),
        .i_off          (w_off),
        .i_wdata        (wdata),
        .o_protected_ok (w_prot_ok),
        .o_state        (w_state),
        .o_sticky       (w_sticky),
        .o_violation    (violation)
    );

    assign w_rell_ok = w_wr && w_prot_ok && (w_off == OFF_RELL);
    assign w_relh_ok = w_wr && w_prot_ok && (w_off == OFF_RELH);
    assign w_cfg_ok  = w_wr && w_prot_ok && (w_off == OFF_CONFIG);

    always_comb begin
        w_status               = 8'h00;
        w_status[STS_UNLOCKED] = (w_state == UNLOCKED);
        w_status[STS_KEY1]     = (w_state == KEY1);
        w_status[STS_STICKY]   = w_sticky;
    end

    always_comb begin
        w_rmux = 8'h00;
        case (w_off)
            OFF_CNTL:   w_rmux = wd_counter_rd[7:0];
            OFF_CNTH:   w_rmux = r_shadow;
            OFF_RELL:   w_rmux = wd_reload_rd[7:0];
            OFF_RELH:   w_rmux = wd_reload_rd[15:8];
            OFF_CONFIG: w_rmux = wd_config_rd;
            OFF_STATUS: w_rmux = w_status;
            default:    w_rmux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata      <= 8'h00;
            r_shadow     <= 8'h00;
            r_counter_wr <= 16'h0000;
            r_reload_wr  <= 16'h0000;
            r_config_wr  <= 8'h00;
            r_counter_we <= 2'b00;
            r_reload_we  <= 2'b00;
            r_config_we  <= 1'b0;
        end else begin
            r_counter_we <= {w_wr && (w_off == OFF_CNTH), w_wr && (w_off == OFF_CNTL)};
            r_reload_we  <= {w_relh_ok, w_rell_ok};
            r_config_we  <= w_cfg_ok;
            if (w_wr && ((w_off == OFF_CNTL) || (w_off == OFF_CNTH)))
                r_counter_wr <= {wdata, wdata};
            if (w_rell_ok || w_relh_ok)
                r_reload_wr <= {wdata, wdata};
            if (w_cfg_ok)
                r_config_wr <= wdata;
            if (w_rd) begin
                r_rdata <= w_rmux;
                // High byte captured with the low byte so a CNTL/CNTH pair is coherent.
                if (w_off == OFF_CNTL)
                    r_shadow <= wd_counter_rd[15:8];
            end
        end
    end

    assign rdata         = r_rdata;
    assign wd_counter_wr = r_counter_wr;
    assign wd_reload_wr  = r_reload_wr;
    assign wd_config_wr  = r_config_wr;
    assign wd_counter_we = r_counter_we;
    assign wd_reload_we  = r_reload_we;
    assign wd_config_we  = r_config_we;

endmodule

// File: doc/wdt_regif.md
# wdt_regif

Byte-wide I/O register interface between the f8 CPU I/O bus and the watchdog timer. It maps 8-bit CPU reads and writes onto the watchdog's 16-bit counter, reload and config registers and their byte write strobes. It returns an atomic 16-bit counter snapshot on reads. It protects reload and config writes behind a two-byte unlock key with a timed window, and flags violations so the SoC can route them to `trap`.

## Interface
Parameters:
- `BASE_ADDR`, 8'h40, I/O base; block decodes when `addr[7:3] == BASE_ADDR[7:3]`; offset = `addr[2:0]`.
- `UNLOCK_WINDOW`, 16, cycles an unlock stays open (range 1..255).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  8  CPU I/O address.
- `wdata`  in  8  CPU write data.
- `wr`  in  1  write strobe, one cycle per access.
- `rd`  in  1  read strobe, one cycle per access.
- `rdata`  out  8  read data, registered.
- `wd_counter_rd`  in  16  watchdog counter value.
- `wd_reload_rd`  in  16  watchdog reload value.
- `wd_config_rd`  in  8  watchdog config value.
- `wd_counter_wr`  out  16  counter write data.
- `wd_reload_wr`  out  16  reload write data.
- `wd_config_wr`  out  8  config write data.
- `wd_counter_we`  out  2  counter byte strobes: bit0 low, bit1 high.
- `wd_reload_we`  out  2  reload byte strobes.
- `wd_config_we`  out  1  config write strobe.
- `violation`  out  1  one-cycle pulse on a protected-access violation.

## Operation
- Offsets:
  - 0 CNTL, 1 CNTH, 2 RELL, 3 RELH, 4 CONFIG, 5 KEY, 6 STATUS.
  - Offset 7 reads 0 and ignores writes.
- Counter writes (CNTL/CNTH) are unprotected; this is the kick path.
  - `wdata` is replicated into both bytes of `wd_counter_wr`.
  - Only the addressed strobe bit is set.
- RELL, RELH and CONFIG are protected.
  - A write is performed only in state UNLOCKED; otherwise it is dropped and is a violation.
- Unlock FSM, states LOCKED, KEY1, UNLOCKED:
  - LOCKED: KEY write 8'h55 -> KEY1. Any other KEY value stays LOCKED, no violation.
  - KEY1: KEY write 8'hAA -> UNLOCKED, window counter := `UNLOCK_WINDOW`. Any other write at an in-range offset -> LOCKED + violation.
  - UNLOCKED:
    - CONFIG write: performed, then -> LOCKED.
    - RELL/RELH writes: performed, state stays UNLOCKED.
    - Window counter decrements each cycle; reaching 0 -> LOCKED, no violation.
    - KEY write of any value -> LOCKED.
- STATUS read: bit0 = UNLOCKED, bit1 = KEY1, bit2 = sticky violation, bits 7:3 = 0.
- STATUS write: a 1 in bit2 clears the sticky bit; other bits are ignored.
- CNTL read returns `wd_counter_rd[7:0]` and latches `wd_counter_rd[15:8]` into the shadow register.
- CNTH read returns the shadow register, not the live counter.
- RELL/RELH/CONFIG reads return live values. KEY reads 0.
- `wr` and `rd` in the same cycle: the write is performed, the read is ignored, `rdata` holds.
- Out-of-range `addr` is ignored entirely; the FSM and window are unaffected.
- Violation sets sticky and pulses `violation`. A violation and a STATUS clear in the same cycle leave sticky = 1.

## Timing
- Reset values:
  - FSM = LOCKED; window counter = 0; shadow = 0; sticky = 0.
  - `rdata` = 0; all `*_we` = 0; all `*_wr` = 0; `violation` = 0.
- Reset mid-unlock aborts to LOCKED, and a pending write strobe is suppressed.
- Write latency: all strobes and data are registered and asserted exactly one cycle after `wr`, for one cycle.
- Read latency: `rdata` is valid the cycle after `rd` and holds until the next read.
- `violation` is asserted the cycle after the offending `wr`.
- Window: the AA write in cycle T opens the window. Protected writes in cycles T+1 .. T+UNLOCK_WINDOW are accepted. The state is LOCKED from cycle T+UNLOCK_WINDOW+1.
- FSM transitions take effect the cycle after `wr`, so back-to-back writes see the updated state.

## Structure
- Package `wdt_pkg` holds:
  - offset localparams;
  - `KEY1_VAL` = 8'h55 and `KEY2_VAL` = 8'hAA;
  - enum `wdt_lock_e` {LOCKED, KEY1, UNLOCKED};
  - STATUS bit-index constants.
- One sub-module is natural: `wdt_unlock_fsm`, containing the FSM, window counter and violation/sticky logic. Its output is `protected_ok`.
- Decode and the read mux stay in the top level.

## Test plan
- Kick: write CNTL=8'h34 -> `wd_counter_we`=2'b01 and `wd_counter_wr[7:0]`=8'h34, one cycle later. Then write CNTH=8'h12 -> `wd_counter_we`=2'b10.
- Locked config: write CONFIG=8'h01 with no key -> `wd_config_we` stays 0, `violation` pulses, STATUS reads 8'h04. Write STATUS=8'h04 -> STATUS reads 8'h00.
- Unlock: KEY 55, KEY AA, RELL=8'h00, RELH=8'hF0, CONFIG=8'h01 -> all three strobes fire. STATUS reads 8'h00 afterwards, and a second CONFIG write is a violation.
- Window expiry, `UNLOCK_WINDOW`=16: AA write at T. RELL write at T+16 is accepted; RELL write at T+17 is dropped with a violation.
- Bad key: KEY 55 then CNTL write -> LOCKED, `violation` pulses, and the CNTL write is still performed.
- Atomic read: counter 16'h12FF. Read CNTL -> 8'hFF. Counter then becomes 16'h1300. Read CNTH -> 8'h12.
